from_hex: RTL and testbench

- ASCII-hex-to-binary decoder: the inverse of the byte-to-hex path.
- Consumes received characters from uart_rx (strobed byte interface).
- Pairs hex digits into bytes, high nibble first.
- Buffers decoded bytes in a small FIFO and presents them on a valid/ready interface to downstream logic (register writer, loopback, LEDs).

---
 rtl/from_hex.sv | 150 +++++++++++++++
 tb/tb_from_hex.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/from_hex.sv
// Purpose: ASCII hex character stream to byte decoder with a small FWFT output FIFO.
// Latency: the completing low-nibble strobe pushes on its edge; the byte is visible on out_data the next cycle.
// Backpressure: out_ready stalls the FIFO only; rx has none, so a push into a full FIFO is dropped and counted.
// Optional: define FROM_HEX_FLUSH_EN so that a separator after a lone nibble emits {4'h0, nibble}.
module from_hex #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_rdy,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             nibble_pending,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] ovf_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {S_HI, S_LO} state_t;

    state_t           state_q, state_d;
    logic [3:0]       held_q, held_d;
    logic [CNT_W-1:0] err_q, ovf_q;

    logic             is_hex, is_sep;
    logic [3:0]       nib;
    logic             push, err_inc;
    logic [7:0]       push_dat;

    logic [7:0]       mem [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q, rd_next;
    logic [7:0]       out_q;
    logic             empty, full, pop, wr_en;

    // Classify the incoming character and extract its nibble value.
    // Letters a-f / A-F have low nibble 1..6, so adding 9 maps them to 10..15.
    always_comb begin
        is_hex = 1'b0;
        is_sep = 1'b0;
        nib    = rx_data[3:0];
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_hex = 1'b1;
        end else if ((rx_data >= 8'h61 && rx_data <= 8'h66) ||
                     (rx_data >= 8'h41 && rx_data <= 8'h46)) begin
            is_hex = 1'b1;
            nib    = rx_data[3:0] + 4'd9;
        end else if (rx_data == 8'h20 || rx_data == 8'h0D ||
                     rx_data == 8'h0A || rx_data == 8'h2C) begin
            is_sep = 1'b1;
        end
    end

    // Nibble-pairing FSM: decides the next state, byte pushes and error events.
    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        push     = 1'b0;
        push_dat = 8'h00;
        err_inc  = 1'b0;
        if (rx_rdy) begin
            case (state_q)
                S_HI: begin
                    if (is_hex) begin
                        held_d  = nib;
                        state_d = S_LO;
                    end else if (!is_sep) begin
                        err_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = S_HI;
                    held_d  = 4'h0;
                    if (is_hex) begin
                        push     = 1'b1;
                        push_dat = {held_q, nib};
                    end else if (is_sep) begin
`ifdef FROM_HEX_FLUSH_EN
                        push     = 1'b1;
                        push_dat = {4'h0, held_q};
`else
                        err_inc  = 1'b1;
`endif
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            endcase
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop     = !empty && out_ready;
        wr_en   = push && (!full || pop);
        rd_next = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    // State, pointers, counters and the registered head byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_HI;
            held_q   <= 4'h0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            out_q    <= 8'h00;
            err_q    <= '0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            rd_ptr_q <= rd_next;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            // Head after this edge: a byte written straight into the head slot bypasses mem.
            if (wr_en && (wr_ptr_q[AW-1:0] == rd_next[AW-1:0])) begin
                out_q <= push_dat;
            end else begin
                out_q <= mem[rd_next[AW-1:0]];
            end
            if (err_inc && err_q != CNT_MAX) begin
                err_q <= err_q + CNT_ONE;
            end
            if (push && !wr_en && ovf_q != CNT_MAX) begin
                ovf_q <= ovf_q + CNT_ONE;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

    assign out_data       = out_q;
    assign out_valid      = !empty;
    assign nibble_pending = (state_q == S_LO);
    assign err_count      = err_q;
    assign ovf_count      = ovf_q;
endmodule

// File: tb/tb_from_hex.sv
// Purpose: randomized and directed stimulus for from_hex against a queue-based reference model.
// Latency: outputs are compared on the falling edge after each rising edge.
// Backpressure: out_ready is driven both in directed patterns and randomly.
module tb_from_hex;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_rdy = 1'b0;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             nibble_pending;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] ovf_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_pend = 1'b0;
    logic [3:0] m_held = 4'h0;
    int         m_err = 0;
    int         m_ovf = 0;
    bit         m_just_rst = 1'b1;

    string hexs = "0123456789abcdefABCDEF";
    string seps = " \r\n,";

    from_hex #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .nibble_pending(nibble_pending), .err_count(err_count), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0 = hex digit, 1 = separator, 2 = invalid
    function automatic int classify(input logic [7:0] c, output logic [3:0] v);
        int x;
        x = int'(c);
        v = 4'h0;
        if (x >= 48 && x <= 57) begin v = 4'(x - 48); return 0; end
        if (x >= 97 && x <= 102) begin v = 4'(x - 87); return 0; end
        if (x >= 65 && x <= 70) begin v = 4'(x - 55); return 0; end
        if (x == 32 || x == 13 || x == 10 || x == 44) return 1;
        return 2;
    endfunction

    task automatic model_edge(input logic r, input logic [7:0] c, input logic ordy, input logic rs);
        logic [3:0] v;
        int         k;
        bit         push;
        bit         pop;
        logic [7:0] b;
        if (rs) begin
            m_q.delete();
            m_pend = 1'b0; m_held = 4'h0; m_err = 0; m_ovf = 0; m_just_rst = 1'b1;
            return;
        end
        m_just_rst = 1'b0;
        pop  = (m_q.size() > 0) && ordy;
        push = 1'b0;
        b    = 8'h00;
        if (r) begin
            k = classify(c, v);
            if (!m_pend) begin
                if (k == 0) begin m_pend = 1'b1; m_held = v; end
                else if (k == 2 && m_err < CMAX) m_err++;
            end else begin
                if (k == 0) begin
                    push = 1'b1; b = {m_held, v};
                end else if (k == 1) begin
`ifdef FROM_HEX_FLUSH_EN
                    push = 1'b1; b = {4'h0, m_held};
`else
                    if (m_err < CMAX) m_err++;
`endif
                end else if (m_err < CMAX) begin
                    m_err++;
                end
                m_pend = 1'b0; m_held = 4'h0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(b);
            else if (m_ovf < CMAX) m_ovf++;
        end
    endtask

    task automatic compare();
        chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) chk("out_data", 32'(out_data), 32'(m_q[0]));
        if (m_just_rst) chk("rst_out_data", 32'(out_data), 32'h0);
        chk("nibble_pending", 32'(nibble_pending), 32'(m_pend));
        chk("err_count", 32'(err_count), 32'(m_err));
        chk("ovf_count", 32'(ovf_count), 32'(m_ovf));
    endtask

    // Called on a falling edge: check current outputs, drive one cycle, advance.
    task automatic step(input logic r, input logic [7:0] c, input logic ordy, input logic rs);
        compare();
        rx_rdy = r; rx_data = c; out_ready = ordy; rst = rs;
        model_edge(r, c, ordy, rs);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_str(input string s, input logic ordy);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i], ordy, 1'b0);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 8'h00, ordy, 1'b0);
    endtask

    task automatic do_rst();
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        int sel;
        int rprob;
        @(negedge clk);
        @(negedge clk);
        do_rst();

        // "41" with the consumer ready
        send_str("41", 1'b1);
        chk("t41_valid", 32'(out_valid), 32'h1);
        chk("t41_data", 32'(out_data), 32'h41);
        idle(1'b1);
        chk("t41_popped", 32'(out_valid), 32'h0);
        chk("t41_err", 32'(err_count), 32'h0);

        // mixed case, buffered then drained back to back
        do_rst();
        send_str("aF0b", 1'b0);
        chk("taf_head", 32'(out_data), 32'hAF);
        idle(1'b1);
        chk("taf_second", 32'(out_data), 32'h0B);
        idle(1'b1);
        chk("taf_empty", 32'(out_valid), 32'h0);

        // invalid characters in HI and LO
        do_rst();
        send_str("G3", 1'b0);
        chk("tg_pending", 32'(nibble_pending), 32'h1);
        send_str("x", 1'b0);
        chk("tg_pending_clr", 32'(nibble_pending), 32'h0);
        chk("tg_err", 32'(err_count), 32'h2);
        chk("tg_nobyte", 32'(out_valid), 32'h0);

        // overflow on the fifth byte
        do_rst();
        send_str("0102030405", 1'b0);
        chk("tovf_count", 32'(ovf_count), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            chk("tovf_drain", 32'(out_data), 32'(i));
            idle(1'b1);
        end
        chk("tovf_empty", 32'(out_valid), 32'h0);

        // pop coincident with a push into a full FIFO
        do_rst();
        send_str("010203040", 1'b0);
        step(1'b1, 8'h35, 1'b1, 1'b0);
        chk("tcoin_ovf", 32'(ovf_count), 32'h0);
        chk("tcoin_head", 32'(out_data), 32'h02);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // lone nibble followed by a separator
        do_rst();
        send_str("7 ", 1'b0);
`ifdef FROM_HEX_FLUSH_EN
        chk("tflush_data", 32'(out_data), 32'h07);
        chk("tflush_err", 32'(err_count), 32'h0);
`else
        chk("tflush_valid", 32'(out_valid), 32'h0);
        chk("tflush_err", 32'(err_count), 32'h1);
`endif

        // reset mid-byte with a coincident strobe
        do_rst();
        send_str("5", 1'b0);
        step(1'b1, 8'h41, 1'b0, 1'b1);
        chk("trst_pending", 32'(nibble_pending), 32'h0);
        chk("trst_valid", 32'(out_valid), 32'h0);
        send_str("5A", 1'b0);
        chk("trst_data", 32'(out_data), 32'h5A);

        // randomized traffic with varying consumer duty cycle
        rprob = 50;
        for (int n = 0; n < 4000; n++) begin
            if (n % 500 == 0) rprob = $urandom_range(0, 100);
            if ($urandom_range(0, 299) == 0) begin
                do_rst();
            end else begin
                sel = $urandom_range(0, 11);
                if (sel <= 5)
                    step(1'b1, hexs[$urandom_range(0, 21)], 1'($urandom_range(0, 99) < rprob), 1'b0);
                else if (sel <= 7)
                    step(1'b1, seps[$urandom_range(0, 3)], 1'($urandom_range(0, 99) < rprob), 1'b0);
                else if (sel <= 8)
                    step(1'b1, 8'($urandom), 1'($urandom_range(0, 99) < rprob), 1'b0);
                else
                    step(1'b0, 8'($urandom), 1'($urandom_range(0, 99) < rprob), 1'b0);
            end
        end
        compare();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
